// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package inst_fetch_pkg;

   localparam int PC_INC     = 4;
   localparam int ALIGN_MASK = 3;

   // Counter width able to hold the values 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO with flush and a registered head entry for the fetch buffer.
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int CW = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      count_next  = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
      // A push landing on the slot that becomes head must bypass the array.
      head_next = (do_push && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (count_next != '0) begin
            head_reg <= head_next;
         end
      end
   end

   assign head  = head_reg;
   assign count = count_reg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC, request credit, redirect/drop tracking and the decode FIFO.
// Optional performance counters are enabled with INST_FETCH_PERF_EN.
module inst_fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter int              INST_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_write,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc
`ifdef INST_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_redirects,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_dropped
`endif
);

   localparam int              CW        = cnt_width(FIFO_DEPTH);
   localparam logic [CW:0]     DEPTH_LIM = FIFO_DEPTH[CW:0];
   localparam logic [PC_W-1:0] PC_STEP   = PC_W'(PC_INC);
   localparam logic [PC_W-1:0] PC_ALIGN  = ~PC_W'(ALIGN_MASK);

   logic [PC_W-1:0]        fetch_pc_reg, resp_pc_reg, redirect_target;
   logic [CW-1:0]          out_cnt_reg, out_cnt_next, drop_cnt_reg, fifo_cnt;
   logic [CW:0]            credit_used;
   logic [INST_W+PC_W-1:0] fifo_head;
   logic                   issue, resp_drop, resp_push, fifo_pop;

   assign credit_used     = {1'b0, fifo_cnt} + {1'b0, out_cnt_reg};
   assign imem_req        = pc_write & ~redirect_valid & ~reset & (credit_used < DEPTH_LIM);
   assign issue           = imem_req & imem_gnt;
   assign imem_addr       = fetch_pc_reg;
   assign resp_drop       = imem_rvalid & (drop_cnt_reg != '0);
   assign resp_push       = imem_rvalid & ~resp_drop & ~redirect_valid;
   assign redirect_target = redirect_pc & PC_ALIGN;
   assign id_valid        = (fifo_cnt != '0) & ~redirect_valid;
   assign fifo_pop        = id_valid & id_ready;
   assign {id_inst, id_pc} = fifo_head;

   always_comb begin
      out_cnt_next = out_cnt_reg;
      if (issue && !imem_rvalid) begin
         out_cnt_next = out_cnt_reg + 1'b1;
      end else if (!issue && imem_rvalid) begin
         out_cnt_next = out_cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg <= RESET_PC;
         resp_pc_reg  <= RESET_PC;
         out_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
      end else if (redirect_valid) begin
         // Every request still in flight after this cycle belongs to the old path;
         // a response arriving now is already removed from out_cnt_next.
         fetch_pc_reg <= redirect_target;
         resp_pc_reg  <= redirect_target;
         out_cnt_reg  <= out_cnt_next;
         drop_cnt_reg <= out_cnt_next;
      end else begin
         if (issue) begin
            fetch_pc_reg <= fetch_pc_reg + PC_STEP;
         end
         if (resp_push) begin
            resp_pc_reg <= resp_pc_reg + PC_STEP;
         end
         if (resp_drop) begin
            drop_cnt_reg <= drop_cnt_reg - 1'b1;
         end
         out_cnt_reg <= out_cnt_next;
      end
   end

   fetch_fifo #(
      .WIDTH (INST_W + PC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (resp_push),
      .push_data ({imem_rdata, resp_pc_reg}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_cnt)
   );

`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_redirects_reg, perf_stall_cycles_reg, perf_dropped_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_redirects_reg    <= '0;
         perf_stall_cycles_reg <= '0;
         perf_dropped_reg      <= '0;
      end else begin
         if (redirect_valid) perf_redirects_reg    <= perf_redirects_reg + 1'b1;
         if (!pc_write)      perf_stall_cycles_reg <= perf_stall_cycles_reg + 1'b1;
         if (resp_drop)      perf_dropped_reg      <= perf_dropped_reg + 1'b1;
      end
   end

   assign perf_redirects    = perf_redirects_reg;
   assign perf_stall_cycles = perf_stall_cycles_reg;
   assign perf_dropped      = perf_dropped_reg;
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised next-generation fetch stage. Keeps the PC register and issues word-aligned requests to an instruction memory that has a request/grant handshake and in-order responses of variable latency. Holds returned instructions in a FIFO that feeds decode through a valid/ready handshake. Branch redirect sets a new PC, flushes queued work and drops in-flight responses; pc_write acts as the stall input.

Parameters:
PC_W, 32, PC/address width; PC increments by 4 modulo 2^PC_W
INST_W, 32, instruction word width
RESET_PC, 0, PC loaded on reset; must be 4-aligned
FIFO_DEPTH, 4, fetch buffer entries; power of two, at least 2; also the outstanding-request limit

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
pc_write  in  1  1 = fetch may issue; 0 = stall, no new request
redirect_valid  in  1  branch taken; redirect_pc becomes the new fetch PC
redirect_pc  in  PC_W  redirect target; bits [1:0] ignored and treated as 0
imem_req  out  1  memory request valid
imem_addr  out  PC_W  request address (current fetch PC)
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  in-order response valid
imem_rdata  in  INST_W  response instruction
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts; transfer when id_valid and id_ready are both 1
id_inst  out  INST_W  FIFO head instruction
id_pc  out  PC_W  PC of id_inst

Behaviour:
- Reset (sync, high): fetch_pc=RESET_PC, FIFO empty, out_cnt=0, drop_cnt=0. Outputs: imem_req=0, id_valid=0, imem_addr=RESET_PC, id_inst=0, id_pc=0. Reset overrides every other input in the same cycle. Reset mid-operation abandons in-flight responses; the memory must also be reset.
- Credit: imem_req = pc_write & ~redirect_valid & ~reset & (fifo_cnt + out_cnt < FIFO_DEPTH). With this limit the FIFO never overflows.
- Issue: when imem_req & imem_gnt, fetch_pc += 4 (wraps, 0x...FFFC -> 0) and out_cnt++. imem_addr always shows fetch_pc.
- Response: each imem_rvalid decrements out_cnt. If drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise {imem_rdata, resp_pc} is pushed, where resp_pc is a separate counter of the next expected response PC, incremented by 4 per accepted response.
- Grant and response in the same cycle: out_cnt is unchanged.
- Latency: request granted in cycle t, earliest rvalid at t+1, earliest id_valid at t+2 (FIFO registered, no bypass).
- Pop: on id_valid & id_ready. Push and pop in the same cycle are allowed at any occupancy; pop while empty is a no-op.
- id_valid = FIFO non-empty & ~redirect_valid. id_inst/id_pc hold the head entry; they are don't-care when id_valid=0 but registered, with no X.
- Redirect (sets priority over everything except reset): next cycle fetch_pc=resp_pc={redirect_pc[PC_W-1:2],2'b00}, FIFO emptied, drop_cnt = out_cnt − (imem_rvalid ? 1 : 0) + drop_cnt_adjust. drop_cnt_adjust removes the double-count when a dropped response arrives in the same cycle. In the redirect cycle, no grant is possible because imem_req=0.
- Back-to-back redirects: the later one wins; drop_cnt is recomputed from live counters.
- pc_write=0: no issue; in-flight responses are still accepted and decode still drains the FIFO.

Optional Feature:
INST_FETCH_PERF_EN. When defined, adds outputs perf_redirects[31:0], perf_stall_cycles[31:0] and perf_dropped[31:0], all 0 on reset and wrapping at 2^32.
- perf_redirects counts cycles with redirect_valid=1.
- perf_stall_cycles counts cycles with pc_write=0.
- perf_dropped counts discarded responses.
When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package inst_fetch_pkg holds PC_INC=4, the alignment mask helper, and the widths of the counter types (clog2(FIFO_DEPTH+1)).
- One sub-module, fetch_fifo: parametrised width/depth synchronous FIFO with flush, push, pop, count, and registered head.
- The top level holds the PC, credit, drop and redirect logic.

Test Plan:
1. Assert reset 2 cycles, then gnt=1 and rvalid 1 cycle after each grant, id_ready=1 -> imem_addr 0,4,8,...; id_pc 0,4,8 starting 2 cycles after the first grant.
2. id_ready=0 with 1-cycle memory -> exactly 4 grants (addr 0..0xC), then imem_req=0. Set id_ready=1 -> issuing resumes at 0x10 and order is preserved.
3. Memory latency 3, two requests outstanding, redirect_pc=0x103 -> two late responses dropped; next id_pc=0x100 with the target's instruction; imem_addr=0x100 the cycle after redirect.
4. pc_write=0 for 5 cycles mid-stream -> no grants, FIFO drains, no PCs skipped or repeated after resume.
5. RESET_PC=0xFFFFFFF8 -> id_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
6. Reset with 3 FIFO entries and 1 outstanding -> next cycle id_valid=0, imem_addr=RESET_PC. With INST_FETCH_PERF_EN, after test 3: perf_redirects=1, perf_dropped=2.
